// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory request/response, pipeline control and fetched output.
// The master side is the fetch controller; the slave side is its environment.
interface fetch_ctrl_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_load;
  logic        freeze;
  logic        flush;
  logic        misprediction;
  logic [31:0] correct_target;
  logic        pred_taken;
  logic [31:0] pc_prediction;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;

  modport master (
    output imem_ren, imem_addr, instr, pc, instr_valid,
    input  imem_ready, imem_load, freeze, flush, misprediction, correct_target,
           pred_taken, pc_prediction
  );

  modport slave (
    input  imem_ren, imem_addr, instr, pc, instr_valid,
    output imem_ready, imem_load, freeze, flush, misprediction, correct_target,
           pred_taken, pc_prediction
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem reads, registers the fetched word and pc,
// parks a word in a skid register on downstream stall and drains redirected requests.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_ctrl_if.master  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc;

  assign next_pc = bus.pred_taken ? bus.pc_prediction : fetch_pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    valid_d       = valid_q & ~bus.flush;

    if (bus.misprediction) begin
      valid_d = 1'b0;
      // An outstanding request must complete before the redirect can be issued.
      if ((state_q == StFetch || state_q == StDrain) && !bus.imem_ready) begin
        redirect_pc_d = bus.correct_target;
        state_d       = StDrain;
      end else begin
        fetch_pc_d = bus.correct_target;
        state_d    = StFetch;
      end
    end else begin
      case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (bus.imem_ready) begin
            if (bus.freeze && !bus.flush) begin
              skid_instr_d = bus.imem_load;
              skid_pc_d    = fetch_pc_q;
              state_d      = StHold;
            end else begin
              instr_d    = bus.imem_load;
              pc_d       = fetch_pc_q;
              valid_d    = ~bus.flush;
              fetch_pc_d = next_pc;
            end
          end
        end
        StHold: begin
          if (!bus.freeze) begin
            instr_d    = skid_instr_q;
            pc_d       = skid_pc_q;
            valid_d    = ~bus.flush;
            fetch_pc_d = next_pc;
            state_d    = StFetch;
          end
        end
        StDrain: begin
          if (bus.imem_ready) begin
            fetch_pc_d = redirect_pc_q;
            state_d    = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= 32'h0;
      skid_instr_q  <= 32'h0;
      skid_pc_q     <= 32'h0;
      instr_q       <= 32'h0;
      pc_q          <= 32'h0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
    end
  end

  assign bus.imem_ren    = (state_q == StFetch) || (state_q == StDrain);
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic, every cycle
// compared against a flag-based behavioural model of the fetch stage.
module tb_fetch_ctrl;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic CLK;
  logic nRST;
  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (ResetPc)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: live = out of the post-reset idle cycle, held = word parked by a stall,
  // drain = a redirect is waiting for the outstanding request to finish.
  bit          m_live, m_held, m_drain;
  logic [31:0] m_fpc, m_rpc, m_skid_i, m_skid_pc, m_instr, m_pc;
  bit          m_valid;
  bit          load_from_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_live = 0; m_held = 0; m_drain = 0;
    m_fpc = ResetPc; m_rpc = '0; m_skid_i = '0; m_skid_pc = '0;
    m_instr = '0; m_pc = '0; m_valid = 0;
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    nxt = bus.pred_taken ? bus.pc_prediction : m_fpc + 32'd4;
    if (bus.flush) m_valid = 0;
    if (bus.misprediction) begin
      m_valid = 0;
      if (m_live && !m_held && !bus.imem_ready) begin
        m_drain = 1;
        m_rpc   = bus.correct_target;
      end else begin
        m_drain = 0;
        m_fpc   = bus.correct_target;
      end
      m_held = 0;
      m_live = 1;
    end else if (!m_live) begin
      m_live = 1;
    end else if (m_drain) begin
      if (bus.imem_ready) begin
        m_drain = 0;
        m_fpc   = m_rpc;
      end
    end else if (m_held) begin
      if (!bus.freeze) begin
        m_instr = m_skid_i; m_pc = m_skid_pc; m_valid = !bus.flush;
        m_fpc   = nxt;      m_held = 0;
      end
    end else if (bus.imem_ready) begin
      if (bus.freeze && !bus.flush) begin
        m_held = 1; m_skid_i = bus.imem_load; m_skid_pc = m_fpc;
      end else begin
        m_instr = bus.imem_load; m_pc = m_fpc; m_valid = !bus.flush;
        m_fpc   = nxt;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ren"},   {31'b0, bus.imem_ren},    {31'b0, m_live && !m_held});
    check({tag, ".addr"},  bus.imem_addr,            m_fpc);
    check({tag, ".instr"}, bus.instr,                m_instr);
    check({tag, ".pc"},    bus.pc,                   m_pc);
    check({tag, ".valid"}, {31'b0, bus.instr_valid}, {31'b0, m_valid});
  endtask

  task automatic set_load();
    bus.imem_load = load_from_addr ? (m_fpc ^ 32'hA5A5_0000) : $urandom();
  endtask

  task automatic tick(input string tag);
    set_load();
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    nRST = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    bus.imem_ready = 0; bus.imem_load = '0; bus.freeze = 0; bus.flush = 0;
    bus.misprediction = 0; bus.correct_target = '0; bus.pred_taken = 0;
    bus.pc_prediction = '0;
    load_from_addr = 1;
    model_reset();
    #2;
    pulse_reset("reset");

    // Streaming fetch with an always-ready memory.
    bus.imem_ready = 1;
    for (int i = 0; i < 3; i++) tick("stream");
    check("stream.addr8", bus.imem_addr, 32'h8);
    check("stream.pc4", bus.pc, 32'h4);
    check("stream.instr4", bus.instr, 32'hA5A5_0004);

    // Predicted-taken branch at pc=8.
    bus.pred_taken = 1; bus.pc_prediction = 32'h100;
    tick("pred");
    check("pred.addr", bus.imem_addr, 32'h100);
    bus.pred_taken = 0;

    // Increment wraps past the top of the address space.
    bus.misprediction = 1; bus.correct_target = 32'hFFFF_FFFC;
    tick("wrap.redir");
    bus.misprediction = 0;
    tick("wrap");
    check("wrap.addr0", bus.imem_addr, 32'h0);

    // Stall while a word returns, then release after three frozen cycles.
    bus.freeze = 1;
    tick("hold.enter");
    check("hold.ren0", {31'b0, bus.imem_ren}, 32'h0);
    for (int i = 0; i < 3; i++) tick("hold");
    bus.freeze = 0;
    tick("hold.release");
    check("hold.pc", bus.pc, 32'h0);
    check("hold.addr", bus.imem_addr, 32'h4);

    // Redirect while a request is pending, then a second redirect during the drain.
    bus.imem_ready = 0; bus.misprediction = 1; bus.correct_target = 32'h200;
    tick("drain.enter");
    bus.misprediction = 0;
    tick("drain.wait");
    bus.misprediction = 1; bus.correct_target = 32'h300;
    tick("drain.second");
    bus.misprediction = 0; bus.imem_ready = 1;
    tick("drain.done");
    check("drain.addr", bus.imem_addr, 32'h300);

    // Flush overrides freeze on an acceptance.
    bus.freeze = 1; bus.flush = 1;
    tick("flush");
    check("flush.valid", {31'b0, bus.instr_valid}, 32'h0);
    check("flush.addr", bus.imem_addr, 32'h304);
    bus.freeze = 0; bus.flush = 0;

    // Reset in the middle of a drain.
    bus.imem_ready = 0; bus.misprediction = 1; bus.correct_target = 32'h400;
    tick("rst.drain");
    bus.misprediction = 0;
    pulse_reset("rst.mid");
    tick("rst.after");
    check("rst.addr", bus.imem_addr, ResetPc);

    // Randomized traffic.
    load_from_addr = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_ready     = ($urandom_range(99) < 60);
      bus.freeze         = ($urandom_range(99) < 30);
      bus.flush          = ($urandom_range(99) < 8);
      bus.misprediction  = ($urandom_range(99) < 6);
      bus.correct_target = $urandom();
      bus.pred_taken     = ($urandom_range(99) < 20);
      bus.pc_prediction  = $urandom();
      if ($urandom_range(199) == 0) pulse_reset("rand.rst");
      else tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
